// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Takes per-class instruction fields and encodes each request as an RV32I
//   word. It writes the words to instruction memory at incrementing word
//   addresses, starting at BASE_ADDR. The core is held in reset (core_hold)
//   until the final instruction (req_last) has been handled.
//
// Parameters:
//   ADDR_W     imem word-address width; capacity is 2**ADDR_W words
//   BASE_ADDR  first word address written after reset / restart
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready    request handshake (ready only while IDLE)
//   req_cls                  0 LW, 1 SW, 2 R, 3 B, 4 I, 5 JAL, 6 CSR, 7 illegal
//   req_rd/rs1/rs2/f3/f7     register and function fields
//   req_imm                  byte-offset immediate, sign-extended
//   req_last                 final instruction of the program
//   restart                  DONE -> IDLE, address back to BASE_ADDR
//   imem_we/addr/wdata       write request, held until imem_ready
//   imem_ready               imem accepts the write this cycle
//   core_hold                1 keeps the core in reset, 0 once loading is done
//   load_done                high in DONE
//   err / err_cnt            sticky reject flag, saturating reject count
//
// Configuration macro:
//   ENC_CHECKSUM_EN  adds output checksum[31:0]. It is the XOR of every word
//                    written to imem, and it is cleared on restart.
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_cls,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_f3,
    input  logic [6:0]        req_f7,
    input  logic [31:0]       req_imm,
    input  logic              req_last,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              core_hold,
    output logic              load_done,
    output logic              err,
    output logic [7:0]        err_cnt
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [2:0] CLS_LW  = 3'd0;
    localparam logic [2:0] CLS_SW  = 3'd1;
    localparam logic [2:0] CLS_R   = 3'd2;
    localparam logic [2:0] CLS_B   = 3'd3;
    localparam logic [2:0] CLS_I   = 3'd4;
    localparam logic [2:0] CLS_JAL = 3'd5;
    localparam logic [2:0] CLS_CSR = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic              last_reg;
    logic [ADDR_W:0]   wr_cnt_reg;    // words written since reset/restart
    logic              err_reg;
    logic [7:0]        err_cnt_reg;

    logic [31:0] enc_word;
    logic        imm_ok;
    logic        fits_s12, fits_s13, fits_s21, fits_u12;
    logic        mem_full;
    logic        accept, legal, reject, wr_done;

    // Immediate range checks: the sign-extended value fits when all bits from
    // the sign position upward are identical.
    assign fits_s12 = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    assign fits_s13 = (&req_imm[31:12]) | ~(|req_imm[31:12]);
    assign fits_s21 = (&req_imm[31:20]) | ~(|req_imm[31:20]);
    assign fits_u12 = ~(|req_imm[31:12]);

    // The top count bit is set exactly when 2**ADDR_W words have been written.
    assign mem_full = wr_cnt_reg[ADDR_W];

    // ---------------- encoder ----------------
    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b0;
        unique case (req_cls)
            CLS_LW: begin
                enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, OP_LOAD};
                imm_ok   = fits_s12;
            end
            CLS_SW: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, req_f3,
                            req_imm[4:0], OP_STORE};
                imm_ok   = fits_s12;
            end
            CLS_R: begin
                enc_word = {req_f7, req_rs2, req_rs1, req_f3, req_rd, OP_R};
                imm_ok   = 1'b1;
            end
            CLS_B: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_f3,
                            req_imm[4:1], req_imm[11], OP_BRANCH};
                imm_ok   = fits_s13 & ~req_imm[0];
            end
            CLS_I: begin
                // Shifts (slli / srli / srai) carry funct7 plus a 5-bit shamt.
                if (req_f3 == 3'd1 || req_f3 == 3'd5) begin
                    enc_word = {req_f7, req_imm[4:0], req_rs1, req_f3, req_rd, OP_IMM};
                end else begin
                    enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, OP_IMM};
                end
                imm_ok = fits_s12;
            end
            CLS_JAL: begin
                enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                            req_rd, OP_JAL};
                imm_ok   = fits_s21 & ~req_imm[0];
            end
            CLS_CSR: begin
                enc_word = {req_imm[11:0], req_rs1, req_f3, req_rd, OP_SYSTEM};
                imm_ok   = fits_u12;
            end
            default: begin
                enc_word = '0;
                imm_ok   = 1'b0;
            end
        endcase
    end

    assign accept  = req_valid & req_ready;
    assign legal   = imm_ok & ~mem_full;
    assign reject  = accept & ~legal;
    assign wr_done = (state_reg == ST_WRITE) & imem_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_next = ST_WRITE;
                    end else if (req_last) begin
                        // A rejected final request still ends the load.
                        state_next = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                if (imem_ready) begin
                    state_next = last_reg ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (state_reg == ST_IDLE);
        imem_we   = (state_reg == ST_WRITE);
        core_hold = (state_reg != ST_DONE);
        load_done = (state_reg == ST_DONE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg    <= BASE;
            wdata_reg   <= '0;
            last_reg    <= 1'b0;
            wr_cnt_reg  <= '0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            if (accept && legal) begin
                wdata_reg <= enc_word;
                last_reg  <= req_last;
            end
            if (reject) begin
                err_reg <= 1'b1;
                if (err_cnt_reg != 8'hFF) begin
                    err_cnt_reg <= err_cnt_reg + 8'd1;
                end
            end
            if (wr_done) begin
                wr_cnt_reg <= wr_cnt_reg + (ADDR_W+1)'(1);
                // The write that fills the memory leaves the address on the
                // last word instead of wrapping back over the program.
                if (!(&wr_cnt_reg[ADDR_W-1:0])) begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                end
            end
            if (state_reg == ST_DONE && restart) begin
                addr_reg   <= BASE;
                wr_cnt_reg <= '0;
            end
        end
    end

    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign err        = err_reg;
    assign err_cnt    = err_cnt_reg;

`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else if (state_reg == ST_DONE && restart) begin
            checksum_reg <= '0;
        end else if (wr_done) begin
            checksum_reg <= checksum_reg ^ wdata_reg;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int ADDR_W = 2;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_cls;
    logic [4:0]        req_rd, req_rs1, req_rs2;
    logic [2:0]        req_f3;
    logic [6:0]        req_f7;
    logic [31:0]       req_imm;
    logic              req_last;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;
    logic              core_hold;
    logic              load_done;
    logic              err;
    logic [7:0]        err_cnt;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cls    (req_cls),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_f3     (req_f3),
        .req_f7     (req_f7),
        .req_imm    (req_imm),
        .req_last   (req_last),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .err        (err),
        .err_cnt    (err_cnt)
`ifdef ENC_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries: {word address, encoded word}.
    logic [63:0] sb_q[$];

    // Reference model state.
    int          m_addr;
    int          m_cnt;
    int          m_err_cnt;
    logic [31:0] m_word;
    logic        m_last;
    logic [31:0] m_chk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [2:0] cls, input logic [31:0] imm, input bit full);
        int s;
        bit ok;
        s = $signed(imm);
        case (cls)
            3'd0, 3'd1, 3'd4: ok = (s >= -2048) && (s <= 2047);
            3'd2:             ok = 1'b1;
            3'd3:             ok = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            3'd5:             ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
            3'd6:             ok = (imm <= 32'h0000_0FFF);
            default:          ok = 1'b0;
        endcase
        return ok && !full;
    endfunction

    // Reference encoder built from shifts and masks.
    function automatic logic [31:0] ref_enc(input logic [2:0] cls, input logic [4:0] rd5,
                                            input logic [4:0] rs15, input logic [4:0] rs25,
                                            input logic [2:0] f33, input logic [6:0] f77,
                                            input logic [31:0] imm);
        logic [31:0] rd, rs1, rs2, f3, f7, w;
        rd = 32'(rd5); rs1 = 32'(rs15); rs2 = 32'(rs25); f3 = 32'(f33); f7 = 32'(f77);
        case (cls)
            3'd0: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
            3'd1: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                      | ((imm & 32'h1F) << 7) | 32'h23;
            3'd2: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            3'd3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                      | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                      | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            3'd4: begin
                if (f3 == 32'd1 || f3 == 32'd5)
                    w = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
                else
                    w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            end
            3'd5: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (rd << 7) | 32'h6F;
            3'd6: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h73;
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Write monitor: every completed imem handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            logic [63:0] e;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                $display("write addr=%0d data=0x%08h (exp addr=%0d data=0x%08h)",
                         imem_addr, imem_wdata, e[63:32], e[31:0]);
                check_eq("wr_addr", 32'(imem_addr), e[63:32]);
                check_eq("wr_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic check_reset_values();
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_imem_we", 32'(imem_we), 32'd0);
        check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_imem_wdata", imem_wdata, 32'd0);
        check_eq("rst_core_hold", 32'(core_hold), 32'd1);
        check_eq("rst_load_done", 32'(load_done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
`ifdef ENC_CHECKSUM_EN
        check_eq("rst_checksum", checksum, 32'd0);
`endif
    endtask

    // Present one request and check the accept cycle.
    // Returns 1 if the model expects a write to follow.
    task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last, output bit wr_expected);
        int n;
        bit ok;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
        req_cls = cls; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_f3 = f3; req_f7 = f7; req_imm = imm; req_last = last;
        req_valid = 1'b1;
        ok = ref_legal(cls, imm, m_cnt >= CAP);
        if (ok) begin
            m_word = ref_enc(cls, rd, rs1, rs2, f3, f7, imm);
            m_last = last;
            sb_q.push_back({32'(m_addr), m_word});
        end
        $display("req cls=%0d imm=0x%08h last=%0d -> %s", cls, imm, last, ok ? "write" : "reject");
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_last  = 1'b0;
        if (ok) begin
            check_eq("we_after_accept", 32'(imem_we), 32'd1);
            check_eq("ready_low_in_write", 32'(req_ready), 32'd0);
            check_eq("addr_in_write", 32'(imem_addr), 32'(m_addr));
        end else begin
            if (m_err_cnt < 255) m_err_cnt++;
            check_eq("we_on_reject", 32'(imem_we), 32'd0);
            check_eq("addr_on_reject", 32'(imem_addr), 32'(m_addr));
            check_eq("err_on_reject", 32'(err), 32'd1);
            check_eq("err_cnt_on_reject", 32'(err_cnt), 32'(m_err_cnt));
            check_eq("done_on_reject", 32'(load_done), 32'(last));
        end
        wr_expected = ok;
    endtask

    // Hold imem_ready low for 'stall' cycles, then complete the write.
    task automatic complete(input int stall);
        for (int i = 0; i < stall; i++) begin
            check_eq("stall_we", 32'(imem_we), 32'd1);
            check_eq("stall_addr", 32'(imem_addr), 32'(m_addr));
            check_eq("stall_data", imem_wdata, m_word);
            check_eq("stall_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        m_cnt++;
        if (m_cnt < CAP) m_addr++;
        m_chk = m_chk ^ m_word;
        check_eq("addr_after_write", 32'(imem_addr), 32'(m_addr));
        check_eq("we_after_write", 32'(imem_we), 32'd0);
        check_eq("ready_after_write", 32'(req_ready), m_last ? 32'd0 : 32'd1);
        check_eq("done_after_write", 32'(load_done), 32'(m_last));
        check_eq("hold_after_write", 32'(core_hold), 32'(!m_last));
`ifdef ENC_CHECKSUM_EN
        check_eq("checksum", checksum, m_chk);
`endif
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        m_addr = 0;
        m_cnt  = 0;
        m_chk  = 32'd0;
        check_eq("restart_addr", 32'(imem_addr), 32'd0);
        check_eq("restart_hold", 32'(core_hold), 32'd1);
        check_eq("restart_done", 32'(load_done), 32'd0);
        check_eq("restart_ready", 32'(req_ready), 32'd1);
        check_eq("restart_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
`ifdef ENC_CHECKSUM_EN
        check_eq("restart_checksum", checksum, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        rst_n = 1'b0; req_valid = 1'b0; req_cls = '0; req_rd = '0; req_rs1 = '0;
        req_rs2 = '0; req_f3 = '0; req_f7 = '0; req_imm = '0; req_last = 1'b0;
        restart = 1'b0; imem_ready = 1'b0;
        m_addr = 0; m_cnt = 0; m_err_cnt = 0; m_word = '0; m_last = 1'b0; m_chk = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LW x5, 8(x2)
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0, w);
        check_eq("lw_word", imem_wdata, 32'h0081_2283);
        check_eq("lw_addr", 32'(imem_addr), 32'd0);
        complete(0);

        // add x1, x2, x3 ; beq x1, x2, +8
        send(3'd2, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, w);
        check_eq("r_word", imem_wdata, 32'h0031_00B3);
        check_eq("r_addr", 32'(imem_addr), 32'd1);
        complete(0);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0, w);
        check_eq("b_word", imem_wdata, 32'h0020_8463);
        check_eq("b_addr", 32'(imem_addr), 32'd2);
        complete(0);

        // Rejections: odd branch offset, illegal class, out-of-range immediates.
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0, w);
        send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, w);
        check_eq("err_cnt_two", 32'(err_cnt), 32'd2);
        send(3'd0, 5'd1, 5'd1, 5'd0, 3'd2, 7'd0, 32'd2048, 1'b0, w);
        send(3'd6, 5'd1, 5'd0, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFFF, 1'b0, w);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 1'b0, w);

        // JAL x1, +16 as final instruction
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1, w);
        check_eq("jal_word", imem_wdata, 32'h0100_00EF);
        check_eq("jal_addr", 32'(imem_addr), 32'd3);
        complete(0);
        do_restart();

        // Stalled store, then fill the remaining words.
        send(3'd1, 5'd0, 5'd2, 5'd7, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b0, w);
        complete(3);
        send(3'd4, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd3, 1'b0, w);
        complete(1);
        send(3'd6, 5'd1, 5'd0, 5'd0, 3'd2, 7'd0, 32'h0000_0C00, 1'b0, w);
        complete(0);
        send(3'd4, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, w);
        complete(0);
        // Memory full: a legal request must be rejected without wrapping.
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0, w);
        check_eq("full_no_wrap_addr", 32'(imem_addr), 32'd3);

        // Rejected final request still finishes the load.
        send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, w);
        check_eq("rej_last_hold", 32'(core_hold), 32'd0);
        do_restart();

        // Reset in the middle of a stalled write.
        send(3'd2, 5'd9, 5'd10, 5'd11, 3'd7, 7'd0, 32'd0, 1'b0, w);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        sb_q.delete();
        m_addr = 0; m_cnt = 0; m_err_cnt = 0; m_chk = '0;
        check_reset_values();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(3'd2, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0, 1'b0, w);
        complete(0);

        repeat (2) @(posedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
